ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 153 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with valid/ready handshaking.
//   SKID=1 : two-entry elastic stage (head + skid), in_ready is registered,
//            so out_ready has no combinational path to in_ready.
//   SKID=0 : single-entry stage, in_ready = !out_valid || out_ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous squash of every held entry (beats transfers)
//   in_valid / in_ready  EX-side handshake; in_* payload fields
//   out_valid / out_ready MEM-side handshake; out_* fields come from the head entry
//   stall_cnt            saturating count of cycles with out_valid && !out_ready
module ex_mem_stage #(
  parameter int PC_W         = 32,
  parameter int DATA_W       = 32,
  parameter int REGNUM_W     = 5,
  parameter int SKID         = 1,
  parameter int OVF_SUPPRESS = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   in_reg_mem_sel,
  input  logic                   in_reg_wr,
  input  logic                   in_mem_en,
  input  logic [DATA_W-1:0]      in_mem_val,
  input  logic [DATA_W-1:0]      in_mem_addr,
  input  logic                   in_overflow,
  input  logic [REGNUM_W-1:0]    in_reg_num,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic                   out_reg_mem_sel,
  output logic                   out_reg_wr,
  output logic                   out_mem_en,
  output logic [DATA_W-1:0]      out_mem_val,
  output logic [DATA_W-1:0]      out_mem_addr,
  output logic                   out_overflow,
  output logic [REGNUM_W-1:0]    out_reg_num,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic                reg_mem_sel;
    logic                reg_wr;
    logic                mem_en;
    logic [DATA_W-1:0]   mem_val;
    logic [DATA_W-1:0]   mem_addr;
    logic                overflow;
    logic [REGNUM_W-1:0] reg_num;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t                 r_state, w_state_nxt;
  entry_t                 r_head, r_skid, w_head_nxt, w_skid_nxt, w_in_entry;
  logic [STALL_CNT_W-1:0] r_stall;
  logic                   w_in_fire, w_out_fire, w_out_valid, w_in_ready;

  assign w_in_entry = '{pc: in_pc, reg_mem_sel: in_reg_mem_sel, reg_wr: in_reg_wr,
                        mem_en: in_mem_en, mem_val: in_mem_val, mem_addr: in_mem_addr,
                        overflow: in_overflow, reg_num: in_reg_num};

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_head_nxt  = w_in_entry;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          case ({w_in_fire, w_out_fire})
            2'b10: begin
              // Only reachable with SKID=1; SKID=0 never accepts without draining.
              if (SKID != 0) begin
                w_skid_nxt  = w_in_entry;
                w_state_nxt = S_FULL;
              end
            end
            2'b01:   w_state_nxt = S_EMPTY;
            2'b11:   w_head_nxt  = w_in_entry;
            default: ;
          endcase
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_head_nxt  = r_skid;
            w_state_nxt = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_skid  <= w_skid_nxt;
      if (w_out_valid && !out_ready && !flush && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;
      // Registered ready: derived from the next state so it already reflects
      // this edge's transfers and flush.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_in_ready <= 1'b0;
        else        r_in_ready <= (w_state_nxt != S_FULL);
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_single
      assign w_in_ready = !w_out_valid || out_ready;
    end
  endgenerate

  assign in_ready        = w_in_ready;
  assign out_valid       = w_out_valid;
  assign out_pc          = r_head.pc;
  assign out_reg_mem_sel = r_head.reg_mem_sel;
  assign out_reg_wr      = r_head.reg_wr && w_out_valid &&
                           !((OVF_SUPPRESS != 0) && r_head.overflow);
  assign out_mem_en      = r_head.mem_en && w_out_valid;
  assign out_mem_val     = r_head.mem_val;
  assign out_mem_addr    = r_head.mem_addr;
  assign out_overflow    = r_head.overflow;
  assign out_reg_num     = r_head.reg_num;
  assign stall_cnt       = r_stall;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        sel;
    logic        wr;
    logic        men;
    logic [31:0] val;
    logic [31:0] addr;
    logic        ovf;
    logic [4:0]  rn;
  } ent_t;

  typedef struct {
    bit          iv;
    logic [31:0] pc;
    bit          ordy;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_rdy;
  } vec_t;

  logic clk, rst_n, flush;
  logic in_valid, out_ready, in_valid_c, out_ready_c;
  ent_t cur;

  // Instance A: SKID=1, OVF_SUPPRESS=1, 16-bit counter
  logic in_ready_a, out_valid_a, out_sel_a, out_wr_a, out_men_a, out_ovf_a;
  logic [31:0] out_pc_a, out_val_a, out_addr_a;
  logic [4:0]  out_rn_a;
  logic [15:0] stall_a;
  // Instance B: SKID=1, OVF_SUPPRESS=0, 4-bit counter, same inputs as A
  logic in_ready_b, out_valid_b, out_sel_b, out_wr_b, out_men_b, out_ovf_b;
  logic [31:0] out_pc_b, out_val_b, out_addr_b;
  logic [4:0]  out_rn_b;
  logic [3:0]  stall_b;
  // Instance C: SKID=0
  logic in_ready_c, out_valid_c, out_sel_c, out_wr_c, out_men_c, out_ovf_c;
  logic [31:0] out_pc_c, out_val_c, out_addr_c;
  logic [4:0]  out_rn_c;
  logic [15:0] stall_c;

  ex_mem_stage #(.SKID(1), .OVF_SUPPRESS(1), .STALL_CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pc(cur.pc), .in_reg_mem_sel(cur.sel), .in_reg_wr(cur.wr), .in_mem_en(cur.men),
    .in_mem_val(cur.val), .in_mem_addr(cur.addr), .in_overflow(cur.ovf), .in_reg_num(cur.rn),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a), .out_reg_mem_sel(out_sel_a),
    .out_reg_wr(out_wr_a), .out_mem_en(out_men_a), .out_mem_val(out_val_a), .out_mem_addr(out_addr_a),
    .out_overflow(out_ovf_a), .out_reg_num(out_rn_a), .stall_cnt(stall_a));

  ex_mem_stage #(.SKID(1), .OVF_SUPPRESS(0), .STALL_CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pc(cur.pc), .in_reg_mem_sel(cur.sel), .in_reg_wr(cur.wr), .in_mem_en(cur.men),
    .in_mem_val(cur.val), .in_mem_addr(cur.addr), .in_overflow(cur.ovf), .in_reg_num(cur.rn),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_reg_mem_sel(out_sel_b),
    .out_reg_wr(out_wr_b), .out_mem_en(out_men_b), .out_mem_val(out_val_b), .out_mem_addr(out_addr_b),
    .out_overflow(out_ovf_b), .out_reg_num(out_rn_b), .stall_cnt(stall_b));

  ex_mem_stage #(.SKID(0), .OVF_SUPPRESS(1), .STALL_CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_pc(cur.pc), .in_reg_mem_sel(cur.sel), .in_reg_wr(cur.wr), .in_mem_en(cur.men),
    .in_mem_val(cur.val), .in_mem_addr(cur.addr), .in_overflow(cur.ovf), .in_reg_num(cur.rn),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_pc(out_pc_c), .out_reg_mem_sel(out_sel_c),
    .out_reg_wr(out_wr_c), .out_mem_en(out_men_c), .out_mem_val(out_val_c), .out_mem_addr(out_addr_c),
    .out_overflow(out_ovf_c), .out_reg_num(out_rn_c), .stall_cnt(stall_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: FIFOs of accepted entries plus saturating counters.
  ent_t qa[$];
  ent_t qc[$];
  int   sa, sb, sc;
  bit   m_rdy_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qc.delete();
    sa = 0; sb = 0; sc = 0;
    m_rdy_a = 1'b0;
  endtask

  task automatic compare_all();
    bit   va, vc;
    ent_t h;
    va = (qa.size() > 0);
    vc = (qc.size() > 0);
    chk("a_valid", out_valid_a, va);
    chk("b_valid", out_valid_b, va);
    chk("a_in_ready", in_ready_a, m_rdy_a);
    chk("b_in_ready", in_ready_b, m_rdy_a);
    chk("a_stall", stall_a, sa);
    chk("b_stall", stall_b, sb);
    chk("c_valid", out_valid_c, vc);
    chk("c_stall", stall_c, sc);
    if (va) begin
      h = qa[0];
      chk("a_pc", out_pc_a, h.pc);
      chk("a_sel", out_sel_a, h.sel);
      chk("a_val", out_val_a, h.val);
      chk("a_addr", out_addr_a, h.addr);
      chk("a_ovf", out_ovf_a, h.ovf);
      chk("a_rn", out_rn_a, h.rn);
      chk("a_reg_wr", out_wr_a, h.wr && !h.ovf);
      chk("a_mem_en", out_men_a, h.men);
      chk("b_pc", out_pc_b, h.pc);
      chk("b_reg_wr", out_wr_b, h.wr);
      chk("b_mem_en", out_men_b, h.men);
    end else begin
      chk("a_reg_wr_idle", out_wr_a, 0);
      chk("a_mem_en_idle", out_men_a, 0);
      chk("b_reg_wr_idle", out_wr_b, 0);
      chk("b_mem_en_idle", out_men_b, 0);
    end
    if (vc) begin
      h = qc[0];
      chk("c_pc", out_pc_c, h.pc);
      chk("c_addr", out_addr_c, h.addr);
      chk("c_reg_wr", out_wr_c, h.wr && !h.ovf);
      chk("c_mem_en", out_men_c, h.men);
    end else begin
      chk("c_reg_wr_idle", out_wr_c, 0);
      chk("c_mem_en_idle", out_men_c, 0);
    end
  endtask

  // One clock: decide transfers from the model, take the edge, update, compare.
  task automatic step();
    bit fa_in, fa_out, fc_in, fc_out, c_rdy;
    #1;
    c_rdy  = (qc.size() == 0) || out_ready_c;
    chk("c_in_ready", in_ready_c, c_rdy);
    fa_in  = in_valid && m_rdy_a;
    fa_out = (qa.size() > 0) && out_ready;
    fc_in  = in_valid_c && c_rdy;
    fc_out = (qc.size() > 0) && out_ready_c;
    @(posedge clk);
    if ((qa.size() > 0) && !out_ready && !flush) begin
      if (sa < 65535) sa++;
      if (sb < 15) sb++;
    end
    if ((qc.size() > 0) && !out_ready_c && !flush && sc < 65535) sc++;
    if (flush) begin
      qa.delete();
      qc.delete();
    end else begin
      if (fa_out) void'(qa.pop_front());
      if (fa_in) qa.push_back(cur);
      if (fc_out) void'(qc.pop_front());
      if (fc_in) qc.push_back(cur);
    end
    m_rdy_a = (qa.size() < 2);
    #1;
    compare_all();
  endtask

  task automatic rand_payload();
    cur.pc   = $urandom;
    cur.sel  = 1'($urandom_range(0, 1));
    cur.wr   = 1'($urandom_range(0, 1));
    cur.men  = 1'($urandom_range(0, 1));
    cur.val  = $urandom;
    cur.addr = $urandom;
    cur.ovf  = 1'($urandom_range(0, 3) == 0);
    cur.rn   = 5'($urandom_range(0, 31));
  endtask

  vec_t        vecs[9];
  logic [31:0] s0, pcc, nexp;
  int          nout;
  bit          acc, outf;

  initial begin
    // Streaming vectors: each pc appears at the output right after its edge.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{iv: 1'b1, pc: 32'h100 + 32'(4 * i), ordy: 1'b1,
                  e_valid: 1'b1, e_pc: 32'h100 + 32'(4 * i), e_rdy: 1'b1};
    vecs[8] = '{iv: 1'b0, pc: 32'h0, ordy: 1'b1, e_valid: 1'b0, e_pc: 32'h0, e_rdy: 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid_c = 1'b0; out_ready_c = 1'b1; cur = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_pc", out_pc_a, 0);
    chk("rst_addr", out_addr_a, 0);
    chk("rst_stall", stall_a, 0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    step();
    chk("post_rst_in_ready", in_ready_a, 1);

    // Streaming
    cur.wr = 1'b1; cur.men = 1'b1;
    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; cur.pc = vecs[i].pc; out_ready = vecs[i].ordy;
      step();
      chk("stream_valid", out_valid_a, vecs[i].e_valid);
      if (vecs[i].e_valid) chk("stream_pc", out_pc_a, vecs[i].e_pc);
      chk("stream_in_ready", in_ready_a, vecs[i].e_rdy);
    end

    // Backpressure with A, B, C
    s0 = 32'(stall_a);
    out_ready = 1'b0; in_valid = 1'b1; cur.pc = 32'hA;
    step();
    chk("bp_head_A", out_pc_a, 32'hA);
    cur.pc = 32'hB;
    step();
    chk("bp_full_rdy", in_ready_a, 0);
    chk("bp_head_A2", out_pc_a, 32'hA);
    cur.pc = 32'hC;
    step();
    chk("bp_hold_A", out_pc_a, 32'hA);
    chk("bp_still_full", in_ready_a, 0);
    out_ready = 1'b1;
    step();
    chk("bp_head_B", out_pc_a, 32'hB);
    chk("bp_rdy_again", in_ready_a, 1);
    step();
    chk("bp_head_C", out_pc_a, 32'hC);
    in_valid = 1'b0;
    step();
    chk("bp_drained", out_valid_a, 0);
    chk("bp_stall_cnt", stall_a, s0 + 2);

    // Flush while FULL with a concurrent input
    out_ready = 1'b0; in_valid = 1'b1; cur.wr = 1'b1; cur.men = 1'b1; cur.ovf = 1'b0;
    cur.pc = 32'hD0; step();
    cur.pc = 32'hE0; step();
    chk("fl_full", in_ready_a, 0);
    flush = 1'b1; cur.pc = 32'hF0; step();
    chk("fl_valid", out_valid_a, 0);
    chk("fl_reg_wr", out_wr_a, 0);
    chk("fl_mem_en", out_men_a, 0);
    chk("fl_in_ready", in_ready_a, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_ghost", out_valid_a, 0);
    // Flush in ONE with an acceptable input: that input is dropped too
    in_valid = 1'b1; cur.pc = 32'h11; step();
    flush = 1'b1; cur.pc = 32'h22; step();
    flush = 1'b0; in_valid = 1'b0; step();
    chk("fl_one_dropped", out_valid_a, 0);

    // Overflow suppression
    in_valid = 1'b1; cur.pc = 32'h200; cur.wr = 1'b1; cur.ovf = 1'b1;
    step();
    chk("ovf_wr_sup", out_wr_a, 0);
    chk("ovf_flag", out_ovf_a, 1);
    chk("ovf_wr_nosup", out_wr_b, 1);
    in_valid = 1'b0; cur.ovf = 1'b0;
    step();

    // SKID=0 with out_ready toggling every cycle
    pcc = 32'h300; nexp = 32'h300; nout = 0;
    in_valid_c = 1'b1;
    for (int cyc = 0; cyc < 100 && nout < 16; cyc++) begin
      out_ready_c = cyc[0];
      cur.pc = pcc;
      #1;
      acc  = in_ready_c;
      outf = out_valid_c && out_ready_c;
      if (outf) begin
        chk("c_order", out_pc_c, nexp);
        nexp += 4;
        nout++;
      end
      step();
      if (acc) pcc += 4;
    end
    chk("c_count", nout, 16);
    in_valid_c = 1'b0; out_ready_c = 1'b1;
    step();

    // Randomised traffic on all three instances against the model
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 9) < 6);
      in_valid_c  = 1'($urandom_range(0, 1));
      out_ready_c = 1'($urandom_range(0, 9) < 6);
      flush       = 1'($urandom_range(0, 19) == 0);
      step();
    end

    // Counter saturation, then asynchronous reset between edges
    flush = 1'b1; in_valid = 1'b0; in_valid_c = 1'b0; out_ready_c = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; cur.pc = 32'h400;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("sat_b", stall_b, 15);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", out_valid_a, 0);
    chk("arst_stall_a", stall_a, 0);
    chk("arst_stall_b", stall_b, 0);
    chk("arst_in_ready", in_ready_a, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("arst_rdy_back", in_ready_a, 1);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
